// File: rtl/aes_pkg.sv
// Shared definitions for the AES ShiftRows engine: default column count,
// Rijndael row offsets, FSM state type and state byte indexing.
// Related build macro: SHIFT_ROWS_INV_EN (enables InvShiftRows datapath).
package aes_pkg;

    localparam int NB_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } shift_rows_state_t;

    // Rijndael row offset C(r); the wide 256-bit block uses 0,1,3,4
    function automatic logic [2:0] row_offset(input int nb, input int r);
        logic [2:0] off;
        case (r)
            0:       off = 3'd0;
            1:       off = 3'd1;
            2:       off = (nb == 8) ? 3'd3 : 3'd2;
            default: off = (nb == 8) ? 3'd4 : 3'd3;
        endcase
        return off;
    endfunction

    // Column-major byte index of state element (row r, column c)
    function automatic int byte_idx(input int c, input int r);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/shift_row_unit.sv
// Combinational single-row rotator. Column 0 of the row sits in the MSB byte.
// Forward rotates left by i_offset, inverse rotates right.
// Build macro: SHIFT_ROWS_INV_EN -- when undefined only the left rotate is
// built and i_dir is ignored.
module shift_row_unit
    import aes_pkg::*;
#(
    parameter int NB = NB_DEFAULT
) (
    input  logic [8*NB-1:0] i_row,
    input  logic [2:0]      i_offset,
    input  logic            i_dir,
    output logic [8*NB-1:0] o_row
);

`ifndef SHIFT_ROWS_INV_EN
    logic w_unused_dir;
    assign w_unused_dir = i_dir;
`endif

    // Select each output column from its rotated source column
    always_comb begin
        int w_src_fwd;
        int w_src;
`ifdef SHIFT_ROWS_INV_EN
        int w_src_inv;
        w_src_inv = 0;
`endif
        o_row     = '0;
        w_src_fwd = 0;
        w_src     = 0;
        for (int c = 0; c < NB; c++) begin
            w_src_fwd = (c + int'(i_offset)) % NB;
`ifdef SHIFT_ROWS_INV_EN
            w_src_inv = (c + NB - int'(i_offset)) % NB;
            w_src     = i_dir ? w_src_inv : w_src_fwd;
`else
            w_src     = w_src_fwd;
`endif
            o_row[8*NB-1-8*c -: 8] = i_row[8*NB-1-8*w_src -: 8];
        end
    end

endmodule

// File: rtl/shift_rows_seq.sv
// Row-serial ShiftRows / InvShiftRows engine over a full Nb-column state.
// ROWS_PER_CYCLE rows are rotated in place per RUN cycle; the result is
// published to state_out in one shot together with a one-cycle done pulse.
// Build macro: SHIFT_ROWS_INV_EN -- when undefined the inv port is ignored
// and only forward ShiftRows is built.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready; start captures state_in/inv into the work/dir registers
//   RUN   | rotate ROWS_PER_CYCLE rows of the work register per cycle
//   DONE  | publish work register to state_out, pulse done, back to IDLE
module shift_rows_seq
    import aes_pkg::*;
#(
    parameter int NB             = NB_DEFAULT,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            inv,
    input  logic [32*NB-1:0] state_in,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [32*NB-1:0] state_out
);

    localparam int W       = 32 * NB;
    localparam int N_STEPS = 4 / ROWS_PER_CYCLE;
    localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

    shift_rows_state_t r_state;
    shift_rows_state_t w_state_nxt;

    logic [W-1:0]    r_work;
    logic [W-1:0]    w_work_nxt;
    logic [1:0]      r_step;
    logic            r_dir;
    logic            r_done;
    logic            w_capture;
    logic            w_finish;

    logic [8*NB-1:0] w_row_in  [ROWS_PER_CYCLE];
    logic [8*NB-1:0] w_row_out [ROWS_PER_CYCLE];
    logic [2:0]      w_off     [ROWS_PER_CYCLE];

    // Row handled by lane j at a given step; wraps so indexing stays in range
    // once step has run past the last slot
    function automatic int row_of(input logic [1:0] step, input int j);
        return (int'(step) * ROWS_PER_CYCLE + j) % 4;
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_step == LAST_STEP) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs and datapath strobes
    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        w_capture = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE: begin
                ready     = 1'b1;
                w_capture = start;
            end
            RUN:     busy     = 1'b1;
            DONE:    w_finish = 1'b1;
            default: ready    = 1'b0;
        endcase
    end

`ifdef SHIFT_ROWS_INV_EN
    // Direction is latched with the accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_dir <= 1'b0;
        else if (w_capture) r_dir <= inv;
    end
`else
    logic w_unused_inv;
    assign w_unused_inv = inv;
    assign r_dir        = 1'b0;
`endif

    // Gather the rows of the current step out of the column-major work register
    always_comb begin
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            w_row_in[j] = '0;
            w_off[j]    = row_offset(NB, row_of(r_step, j));
            for (int c = 0; c < NB; c++) begin
                w_row_in[j][8*NB-1-8*c -: 8] =
                    r_work[W-1-8*byte_idx(c, row_of(r_step, j)) -: 8];
            end
        end
    end

    for (genvar j = 0; j < ROWS_PER_CYCLE; j++) begin : g_lane
        shift_row_unit #(
            .NB(NB)
        ) u_row (
            .i_row    (w_row_in[j]),
            .i_offset (w_off[j]),
            .i_dir    (r_dir),
            .o_row    (w_row_out[j])
        );
    end

    // Scatter rotated rows back; untouched rows keep their current bytes
    always_comb begin
        w_work_nxt = r_work;
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            for (int c = 0; c < NB; c++) begin
                w_work_nxt[W-1-8*byte_idx(c, row_of(r_step, j)) -: 8] =
                    w_row_out[j][8*NB-1-8*c -: 8];
            end
        end
    end

    // Work register, step counter and result register; done is registered so
    // it rises in the same cycle state_out takes its new value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work    <= '0;
            r_step    <= '0;
            state_out <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_work <= state_in;
                r_step <= '0;
            end else if (busy) begin
                r_work <= w_work_nxt;
                r_step <= r_step + 2'd1;
            end
            if (w_finish) begin
                state_out <= r_work;
                r_done    <= 1'b1;
            end
        end
    end

    assign done = r_done;

endmodule
